// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with a built-in prescaler.
// Q, step and rollover are all registered; step/rollover are one-cycle pulses.
module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100_000_000,
    parameter int DIV_W    = 27
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  step,
    output logic                  rollover
);

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

    logic [4*DIGITS-1:0] q_q, q_d;
    logic [DIV_W-1:0]    presc_q, presc_d;
    logic                step_q, step_d;
    logic                roll_q, roll_d;

    logic [4*DIGITS-1:0] cnt_next;
    logic [4*DIGITS-1:0] load_clean;
    logic                carry;
    logic [3:0]          digit;

    // Ripple a carry/borrow from digit 0 upward; carry surviving the top digit means wrap.
    always_comb begin
        carry    = 1'b1;
        digit    = 4'd0;
        cnt_next = q_q;
        for (int i = 0; i < DIGITS; i++) begin
            digit = q_q[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (digit >= 4'd9) begin
                        cnt_next[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_next[4*i +: 4] = digit + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        cnt_next[4*i +: 4] = 4'd9;
                    end else begin
                        cnt_next[4*i +: 4] = digit - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    // Non-decimal load digits are forced to 0 so Q never holds 10..15.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] <= 4'd9) begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    always_comb begin
        q_d     = q_q;
        presc_d = presc_q;
        step_d  = 1'b0;
        roll_d  = 1'b0;
        if (clr) begin
            q_d     = '0;
            presc_d = '0;
        end else if (load) begin
            q_d     = load_clean;
            presc_d = '0;
        end else if (en) begin
            if (presc_q == TICK_LAST) begin
                presc_d = '0;
                q_d     = cnt_next;
                step_d  = 1'b1;
                roll_d  = carry;
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= '0;
            presc_q <= '0;
            step_q  <= 1'b0;
            roll_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            roll_q  <= roll_d;
        end
    end

    assign Q        = q_q;
    assign step     = step_q;
    assign rollover = roll_q;

endmodule
